// File: rtl/fpdiv_issue_arbiter_pkg.sv
// fpdiv_arb_pkg: shared defaults and in-flight tag type for the divider issue arbiter
package fpdiv_arb_pkg;
  localparam int DIV_LATENCY_DFLT = 8;
  localparam int RSP_DEPTH_DFLT = 4;
  localparam int REQ_CNT = 2;
  typedef struct packed {
    logic v;
    logic id;
  } tag_t;
endpackage

// File: rtl/fpdiv_issue_arbiter_if.sv
// fpdiv_issue_arbiter_if: requester, response and divider-side signals; FPDIV_ARB_STATS_EN adds counters
interface fpdiv_issue_arbiter_if;
  logic        req0_valid, req0_ready, req1_valid, req1_ready;
  logic [31:0] req0_a, req0_b, req1_a, req1_b;
  logic        rsp0_valid, rsp0_ready, rsp1_valid, rsp1_ready;
  logic [31:0] rsp0_data, rsp1_data;
  logic [31:0] div_a, div_b, div_c;
  logic        div_d;
`ifdef FPDIV_ARB_STATS_EN
  logic [31:0] stat_issue0, stat_issue1, stat_block;
`endif
  modport master (
`ifdef FPDIV_ARB_STATS_EN
    input  stat_issue0, stat_issue1, stat_block,
`endif
    output req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    output rsp0_ready, rsp1_ready, div_c,
    input  req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    input  div_a, div_b, div_d
  );
  modport slave (
`ifdef FPDIV_ARB_STATS_EN
    output stat_issue0, stat_issue1, stat_block,
`endif
    input  req0_valid, req0_a, req0_b, req1_valid, req1_a, req1_b,
    input  rsp0_ready, rsp1_ready, div_c,
    output req0_ready, req1_ready, rsp0_valid, rsp0_data, rsp1_valid, rsp1_data,
    output div_a, div_b, div_d
  );
endinterface

// File: rtl/fpdiv_issue_arbiter_fifo.sv
// fpdiv_rsp_fifo: circular 32-bit response FIFO with wrap-bit pointers
module fpdiv_rsp_fifo #(
  parameter int DEPTH = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        push,
  input  logic [31:0] din,
  input  logic        pop,
  output logic [31:0] dout,
  output logic        full,
  output logic        empty
);
  localparam int AW = $clog2(DEPTH);
  logic [AW:0]  wp, rp;
  logic [31:0]  mem [DEPTH];
  logic         wr;
  assign empty = wp == rp;
  assign full  = (wp[AW] != rp[AW]) && (wp[AW-1:0] == rp[AW-1:0]);
  assign dout  = mem[rp[AW-1:0]];
  assign wr    = push && (!full || pop);
  // pointer advance; a pop on a full FIFO frees the slot the same-cycle push lands in
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      wp <= '0;
      rp <= '0;
    end else begin
      if (wr) wp <= wp + 1'b1;
      if (pop && !empty) rp <= rp + 1'b1;
    end
  // storage needs no reset: contents are ignored while empty
  always_ff @(posedge clk)
    if (wr) mem[wp[AW-1:0]] <= din;
endmodule

// File: rtl/fpdiv_issue_arbiter.sv
// fpdiv_issue_arbiter: round-robin sharing of one pipelined divider; FPDIV_ARB_STATS_EN adds issue/block counters
module fpdiv_issue_arbiter
  import fpdiv_arb_pkg::*;
#(
  parameter int DIV_LATENCY = DIV_LATENCY_DFLT,
  parameter int RSP_DEPTH   = RSP_DEPTH_DFLT
) (
  input logic                 clk,
  input logic                 rst,
  fpdiv_issue_arbiter_if.slave bus
);
  localparam int CW = $clog2(RSP_DEPTH + 1);
  logic [CW-1:0] credit0, credit1;
  logic          prio, elig0, elig1, grant0, grant1, pop0, pop1;
  logic          full0, full1, empty0, empty1;
  tag_t          tags [DIV_LATENCY+1];
  tag_t          tail;
  // eligibility, round-robin grant and pops; ready held low while reset is asserted
  always_comb begin
    elig0  = bus.req0_valid && credit0 < CW'(RSP_DEPTH) && !full0;
    elig1  = bus.req1_valid && credit1 < CW'(RSP_DEPTH) && !full1;
    grant0 = rst && elig0 && (!elig1 || !prio);
    grant1 = rst && elig1 && (!elig0 || prio);
    pop0   = !empty0 && bus.rsp0_ready;
    pop1   = !empty1 && bus.rsp1_ready;
  end
  assign bus.req0_ready = grant0;
  assign bus.req1_ready = grant1;
  assign bus.rsp0_valid = !empty0;
  assign bus.rsp1_valid = !empty1;
  assign tail = tags[DIV_LATENCY];
  // divider-side operand registers, rr pointer and per-requester credits
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.div_a <= '0;
      bus.div_b <= '0;
      bus.div_d <= 1'b0;
      prio      <= 1'b0;
      credit0   <= '0;
      credit1   <= '0;
    end else begin
      bus.div_d <= grant0 || grant1;
      if (grant0 || grant1) begin
        bus.div_a <= grant1 ? bus.req1_a : bus.req0_a;
        bus.div_b <= grant1 ? bus.req1_b : bus.req0_b;
        prio      <= grant0;
      end
      credit0 <= credit0 + CW'(grant0) - CW'(pop0);
      credit1 <= credit1 + CW'(grant1) - CW'(pop1);
    end
  // stage 0 lines up with div_d; the divider samples it an edge later, so the tail meets div_c
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      for (int i = 0; i <= DIV_LATENCY; i++) tags[i] <= '0;
    end else begin
      tags[0] <= '{v: grant0 || grant1, id: grant1};
      for (int i = 1; i <= DIV_LATENCY; i++) tags[i] <= tags[i-1];
    end
  fpdiv_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo0 (
    .clk(clk), .rst(rst), .push(tail.v && !tail.id), .din(bus.div_c), .pop(pop0),
    .dout(bus.rsp0_data), .full(full0), .empty(empty0)
  );
  fpdiv_rsp_fifo #(.DEPTH(RSP_DEPTH)) u_fifo1 (
    .clk(clk), .rst(rst), .push(tail.v && tail.id), .din(bus.div_c), .pop(pop1),
    .dout(bus.rsp1_data), .full(full1), .empty(empty1)
  );
`ifdef FPDIV_ARB_STATS_EN
  // issue counts per requester and cycles where a valid request sat out on exhausted credit
  always_ff @(posedge clk or negedge rst)
    if (!rst) begin
      bus.stat_issue0 <= '0;
      bus.stat_issue1 <= '0;
      bus.stat_block  <= '0;
    end else begin
      bus.stat_issue0 <= bus.stat_issue0 + 32'(grant0);
      bus.stat_issue1 <= bus.stat_issue1 + 32'(grant1);
      bus.stat_block  <= bus.stat_block + 32'((bus.req0_valid && credit0 >= CW'(RSP_DEPTH)) ||
                                              (bus.req1_valid && credit1 >= CW'(RSP_DEPTH)));
    end
`endif
endmodule

// File: tb/tb_fpdiv_issue_arbiter.sv
// tb_fpdiv_issue_arbiter: randomized bench with a queue-based reference model and a behavioural divider
module tb_fpdiv_issue_arbiter;
  import fpdiv_arb_pkg::*;
  localparam int L = DIV_LATENCY_DFLT;
  localparam int D = RSP_DEPTH_DFLT;
  localparam logic [31:0] ONE = 32'h3F800000;

  typedef struct {
    logic [31:0] d;
    int          arr;
  } ent_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   tests = 0, fails = 0;

  fpdiv_issue_arbiter_if bus();
  fpdiv_issue_arbiter dut (.clk(clk), .rst(rst), .bus(bus));

  always #5 clk = ~clk;

  function automatic real s2r(input logic [31:0] a);
    if (a[30:0] == 31'd0) return 0.0;
    return $bitstoreal({a[31], 11'(a[30:23]) + 11'd896, a[22:0], 29'd0});
  endfunction

  function automatic logic [31:0] fdiv(input logic [31:0] a, input logic [31:0] b);
    logic [63:0] qb;
    if (a[30:0] == 31'd0) return {a[31] ^ b[31], 31'd0};
    qb = $realtobits(s2r(a) / s2r(b));
    return {qb[63], 8'(qb[62:52] - 11'd896), qb[51:29]};
  endfunction

  function automatic logic [31:0] rand_f();
    return {1'($urandom), 8'($urandom_range(144, 110)), 23'($urandom)};
  endfunction

  logic [31:0] dpipe [L];
  assign bus.div_c = dpipe[L-1];
  always @(posedge clk) begin
    dpipe[0] <= bus.div_d ? fdiv(bus.div_a, bus.div_b) : 32'hDEAD_BEEF;
    for (int i = 1; i < L; i++) dpipe[i] <= dpipe[i-1];
  end

  ent_t q0[$], q1[$];
  bit   mon = 1'b0, pref1 = 1'b0;
  bit   g0, g1, p0, p1, e0, e1, v0, v1, blk;
  int   cyc = 0, st_i0 = 0, st_i1 = 0, st_blk = 0;

  always @(negedge clk) if (mon) begin
    e0 = bus.req0_valid && q0.size() < D;
    e1 = bus.req1_valid && q1.size() < D;
    g0 = e0 && (!e1 || !pref1);
    g1 = e1 && (!e0 || pref1);
    v0 = q0.size() > 0 && q0[0].arr <= cyc;
    v1 = q1.size() > 0 && q1[0].arr <= cyc;
    blk = (bus.req0_valid && q0.size() >= D) || (bus.req1_valid && q1.size() >= D);
    tests += 4;
    if (bus.req0_ready !== g0) begin fails++; $display("FAIL mon_ready0 cyc=%0d got=%b exp=%b", cyc, bus.req0_ready, g0); end
    if (bus.req1_ready !== g1) begin fails++; $display("FAIL mon_ready1 cyc=%0d got=%b exp=%b", cyc, bus.req1_ready, g1); end
    if (bus.rsp0_valid !== v0) begin fails++; $display("FAIL mon_rsp0_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp0_valid, v0); end
    if (bus.rsp1_valid !== v1) begin fails++; $display("FAIL mon_rsp1_valid cyc=%0d got=%b exp=%b", cyc, bus.rsp1_valid, v1); end
    if (v0) begin
      tests++;
      if (bus.rsp0_data !== q0[0].d) begin fails++; $display("FAIL mon_rsp0_data cyc=%0d got=%h exp=%h", cyc, bus.rsp0_data, q0[0].d); end
    end
    if (v1) begin
      tests++;
      if (bus.rsp1_data !== q1[0].d) begin fails++; $display("FAIL mon_rsp1_data cyc=%0d got=%h exp=%h", cyc, bus.rsp1_data, q1[0].d); end
    end
    p0 = v0 && bus.rsp0_ready;
    p1 = v1 && bus.rsp1_ready;
  end

  always @(posedge clk) if (mon) begin
    cyc++;
    if (p0) void'(q0.pop_front());
    if (p1) void'(q1.pop_front());
    if (g0) q0.push_back('{fdiv(bus.req0_a, bus.req0_b), cyc + L + 1});
    if (g1) q1.push_back('{fdiv(bus.req1_a, bus.req1_b), cyc + L + 1});
    if (g0 || g1) pref1 = g0;
    st_i0 += int'(g0);
    st_i1 += int'(g1);
    st_blk += int'(blk);
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic model_clear();
    q0.delete();
    q1.delete();
    pref1 = 0; g0 = 0; g1 = 0; p0 = 0; p1 = 0;
    st_i0 = 0; st_i1 = 0; st_blk = 0;
  endtask

  task automatic idle();
    bus.req0_valid = 0; bus.req1_valid = 0;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
  endtask

  task automatic drain();
    idle();
    repeat (L + D + 6) tick();
  endtask

  task automatic test_reset();
    bus.req0_valid = 1; bus.req1_valid = 1;
    bus.req0_a = 32'h40000000; bus.req0_b = ONE;
    bus.req1_a = 32'h40000000; bus.req1_b = ONE;
    bus.rsp0_ready = 1; bus.rsp1_ready = 1;
    #1 rst = 0;
    #2;
    tests += 5;
    if (bus.div_d !== 1'b0) begin fails++; $display("FAIL reset_div_d got=%b exp=0", bus.div_d); end
    if (bus.div_a !== 32'd0) begin fails++; $display("FAIL reset_div_a got=%h exp=0", bus.div_a); end
    if (bus.rsp0_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp0_valid got=%b exp=0", bus.rsp0_valid); end
    if (bus.rsp1_valid !== 1'b0) begin fails++; $display("FAIL reset_rsp1_valid got=%b exp=0", bus.rsp1_valid); end
    if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL reset_ready0 got=%b exp=0", bus.req0_ready); end
    repeat (2) tick();
    tests++;
    if (bus.div_d !== 1'b0) begin fails++; $display("FAIL reset_hold_div_d got=%b exp=0", bus.div_d); end
    idle();
    rst = 1;
    model_clear();
    mon = 1;
    tick();
  endtask

  task automatic test_single();
    int  n = 0;
    bit  saw1 = 0;
    bus.rsp0_ready = 0;
    bus.req0_a = 32'h40000000; bus.req0_b = ONE; bus.req0_valid = 1;
    @(negedge clk);
    tests++;
    if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL single_grant got=%b exp=1", bus.req0_ready); end
    tick();
    bus.req0_valid = 0;
    while (!bus.rsp0_valid && n < 40) begin
      saw1 |= bus.rsp1_valid;
      tick();
      n++;
    end
    tests += 3;
    if (n != L + 1) begin fails++; $display("FAIL single_latency got=%0d exp=%0d", n, L + 1); end
    if (bus.rsp0_data !== 32'h40000000) begin fails++; $display("FAIL single_data got=%h exp=40000000", bus.rsp0_data); end
    if (saw1 || bus.rsp1_valid) begin fails++; $display("FAIL single_rsp1_quiet got=1 exp=0"); end
    bus.rsp0_ready = 1;
    drain();
  endtask

  task automatic test_alternate();
    int n0 = 0, n1 = 0, r0 = 0, r1 = 0, last = -1, cur;
    bus.req0_a = 32'h42000000; bus.req0_b = 32'h40000000;
    bus.req1_a = 32'h3FC00000; bus.req1_b = 32'h3E000000;
    bus.req0_valid = 1; bus.req1_valid = 1;
    repeat (2 * D) begin
      @(negedge clk);
      cur = bus.req1_ready ? 1 : 0;
      tests++;
      if ((bus.req0_ready ^ bus.req1_ready) !== 1'b1 || cur == last) begin
        fails++; $display("FAIL alt_grant got=%b%b last=%0d exp=alternating single grant", bus.req0_ready, bus.req1_ready, last);
      end
      last = cur;
      n0 += int'(bus.req0_ready);
      n1 += int'(bus.req1_ready);
      tick();
    end
    idle();
    repeat (L + D + 4) begin
      @(negedge clk);
      if (bus.rsp0_valid) begin
        r0++; tests++;
        if (bus.rsp0_data !== 32'h41800000) begin fails++; $display("FAIL alt_rsp0 got=%h exp=41800000", bus.rsp0_data); end
      end
      if (bus.rsp1_valid) begin
        r1++; tests++;
        if (bus.rsp1_data !== 32'h41400000) begin fails++; $display("FAIL alt_rsp1 got=%h exp=41400000", bus.rsp1_data); end
      end
      tick();
    end
    tests += 2;
    if (n0 != D || n1 != D) begin fails++; $display("FAIL alt_counts got=%0d/%0d exp=%0d/%0d", n0, n1, D, D); end
    if (r0 != D || r1 != D) begin fails++; $display("FAIL alt_rsp_counts got=%0d/%0d exp=%0d/%0d", r0, r1, D, D); end
    drain();
  endtask

  task automatic test_credit();
    int n0 = 0, n1 = 0;
    bus.rsp0_ready = 0; bus.rsp1_ready = 1;
    bus.req0_a = 32'h40400000; bus.req0_b = 32'h40000000;
    bus.req1_a = 32'h41200000; bus.req1_b = 32'h40800000;
    bus.req0_valid = 1; bus.req1_valid = 1;
    repeat (40) begin
      @(negedge clk);
      n0 += int'(bus.req0_ready);
      n1 += int'(bus.req1_ready);
      tick();
    end
    @(negedge clk);
    tests += 3;
    if (n0 != D) begin fails++; $display("FAIL credit_grants0 got=%0d exp=%0d", n0, D); end
    if (n1 < 2 * D) begin fails++; $display("FAIL credit_req1_blocked got=%0d exp>=%0d", n1, 2 * D); end
    if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL credit_ready0 got=%b exp=0", bus.req0_ready); end
    tick();
    bus.rsp0_ready = 1;
    n0 = 0;
    @(negedge clk);
    n0 += int'(bus.req0_ready);
    tick();
    bus.rsp0_ready = 0;
    repeat (30) begin
      @(negedge clk);
      n0 += int'(bus.req0_ready);
      tick();
    end
    tests++;
    if (n0 != 1) begin fails++; $display("FAIL credit_after_pop got=%0d exp=1", n0); end
    drain();
  endtask

  task automatic test_full_pushpop();
    logic [31:0] ops [4];
    ops[0] = 32'h447A0000; ops[1] = 32'h3B03126F; ops[2] = 32'h40000000; ops[3] = 32'h40400000;
    bus.rsp0_ready = 0;
    bus.req0_b = ONE;
    for (int i = 0; i < 4; i++) begin
      bus.req0_a = ops[i]; bus.req0_valid = 1;
      tick();
    end
    bus.req0_valid = 0;
    repeat (L + 3) tick();
    bus.req0_a = ONE; bus.req0_valid = 1; bus.rsp0_ready = 1;
    @(negedge clk);
    tests += 2;
    if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL full_ready_at4 got=%b exp=0", bus.req0_ready); end
    if (bus.rsp0_data !== 32'h447A0000) begin fails++; $display("FAIL full_head0 got=%h exp=447a0000", bus.rsp0_data); end
    tick();
    @(negedge clk);
    tests += 2;
    if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL full_ready_at3 got=%b exp=1", bus.req0_ready); end
    if (bus.rsp0_data !== 32'h3B03126F) begin fails++; $display("FAIL full_head1 got=%h exp=3b03126f", bus.rsp0_data); end
    tick();
    bus.rsp0_ready = 0;
    @(negedge clk);
    tests++;
    if (bus.req0_ready !== 1'b1) begin fails++; $display("FAIL full_pushpop_credit got=%b exp=1", bus.req0_ready); end
    tick();
    @(negedge clk);
    tests++;
    if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL full_refill got=%b exp=0", bus.req0_ready); end
    tick();
    drain();
  endtask

  task automatic test_reset_inflight();
    bit stale = 0;
    bus.req0_a = rand_f(); bus.req0_b = rand_f();
    bus.req1_a = rand_f(); bus.req1_b = rand_f();
    bus.req0_valid = 1; bus.req1_valid = 1;
    repeat (3) tick();
    mon = 0;
    rst = 0;
    #1;
    tests += 4;
    if (bus.div_d !== 1'b0) begin fails++; $display("FAIL rstfly_div_d got=%b exp=0", bus.div_d); end
    if (bus.rsp0_valid !== 1'b0) begin fails++; $display("FAIL rstfly_rsp0 got=%b exp=0", bus.rsp0_valid); end
    if (bus.rsp1_valid !== 1'b0) begin fails++; $display("FAIL rstfly_rsp1 got=%b exp=0", bus.rsp1_valid); end
    if (bus.req0_ready !== 1'b0) begin fails++; $display("FAIL rstfly_ready0 got=%b exp=0", bus.req0_ready); end
    repeat (2) tick();
    idle();
    rst = 1;
    model_clear();
    mon = 1;
    repeat (L + 8) begin
      @(negedge clk);
      stale |= bus.rsp0_valid | bus.rsp1_valid;
      tick();
    end
    tests++;
    if (stale) begin fails++; $display("FAIL rstfly_stale got=1 exp=0"); end
  endtask

  task automatic test_random();
    repeat (400) begin
      bus.req0_valid = ($urandom_range(9, 0) < 7);
      bus.req1_valid = ($urandom_range(9, 0) < 7);
      bus.rsp0_ready = ($urandom_range(9, 0) < 6);
      bus.rsp1_ready = ($urandom_range(9, 0) < 6);
      bus.req0_a = rand_f(); bus.req0_b = rand_f();
      bus.req1_a = rand_f(); bus.req1_b = rand_f();
      tick();
    end
    drain();
  endtask

`ifdef FPDIV_ARB_STATS_EN
  task automatic test_stats();
    @(negedge clk);
    tests += 3;
    if (bus.stat_issue0 !== 32'(st_i0)) begin fails++; $display("FAIL stat_issue0 got=%0d exp=%0d", bus.stat_issue0, st_i0); end
    if (bus.stat_issue1 !== 32'(st_i1)) begin fails++; $display("FAIL stat_issue1 got=%0d exp=%0d", bus.stat_issue1, st_i1); end
    if (bus.stat_block !== 32'(st_blk)) begin fails++; $display("FAIL stat_block got=%0d exp=%0d", bus.stat_block, st_blk); end
    tick();
  endtask
`endif

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1);
  end

  initial begin
    idle();
    bus.req0_a = '0; bus.req0_b = ONE; bus.req1_a = '0; bus.req1_b = ONE;
    test_reset();
    test_single();
    test_alternate();
    test_credit();
    test_full_pushpop();
    test_reset_inflight();
    test_random();
`ifdef FPDIV_ARB_STATS_EN
    test_stats();
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
